// File: rtl/kernel_launch_ctrl.sv
// kernel_launch_ctrl: issues ap_start a requested number of times, waits on ap_done, reports runs/cycles/timeout.
module kernel_launch_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int CYC_WIDTH = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  output logic                 ap_start,
  input  logic                 ap_ready,
  input  logic                 ap_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CNT_WIDTH-1:0] rsp_runs,
  output logic [CYC_WIDTH-1:0] rsp_cycles,
  output logic                 rsp_timeout,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state, next;
  logic [CNT_WIDTH-1:0] count, runs;
  logic [CYC_WIDTH-1:0] cycles, wd;
  logic tflag, active, tout, more;
  assign active = state == LAUNCH || state == WAIT;
  // expiry only counts when the cycle carries no terminating event, so a tie goes to the event
  assign tout = TIMEOUT != 0 && wd == CYC_WIDTH'(TIMEOUT - 1) &&
                (state == LAUNCH ? !ap_ready : state == WAIT && !ap_done);
  assign more = ({1'b0, runs} + (CNT_WIDTH+1)'(1)) < {1'b0, count};
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = cmd_valid ? (cmd_count == '0 ? RESP : LAUNCH) : IDLE;
      LAUNCH:  next = ap_ready ? WAIT : tout ? RESP : LAUNCH;
      WAIT:    next = ap_done ? (more ? LAUNCH : RESP) : tout ? RESP : WAIT;
      default: next = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_comb begin
    cmd_ready   = state == IDLE;
    ap_start    = state == LAUNCH;
    rsp_valid   = state == RESP;
    busy        = state != IDLE;
    rsp_runs    = runs;
    rsp_cycles  = cycles;
    rsp_timeout = tflag;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      runs   <= '0;
      cycles <= '0;
      wd     <= '0;
      tflag  <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        count  <= cmd_count;
        runs   <= '0;
        cycles <= '0;
        tflag  <= 1'b0;
      end
      if (active && !(&cycles)) cycles <= cycles + CYC_WIDTH'(1);
      if (state == WAIT && ap_done) runs <= runs + CNT_WIDTH'(1);
      if (tout) tflag <= 1'b1;
      wd <= (next == LAUNCH && state != LAUNCH) ? '0 : active ? wd + CYC_WIDTH'(1) : wd;
    end
  end
endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// tb_kernel_launch_ctrl: directed bench with a latency-3 kernel model and a TIMEOUT=4 watchdog.
module tb_kernel_launch_ctrl;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, ap_start, ap_ready, ap_done, rsp_valid, rsp_ready = 1;
  logic rsp_timeout, busy;
  logic [15:0] cmd_count = 0, rsp_runs;
  logic [31:0] rsp_cycles;
  logic k_busy, hang = 0;
  int k_cnt;
  int checks = 0, errors = 0;
  int n;
  logic [31:0] starts;

  kernel_launch_ctrl #(.CNT_WIDTH(16), .CYC_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_runs(rsp_runs), .rsp_cycles(rsp_cycles),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // kernel: idle means ready; done pulses in the 3rd cycle after the accept edge
  assign ap_ready = !k_busy;
  assign ap_done  = k_busy && k_cnt == 3 && !hang;
  always @(posedge clk) begin
    if (rst) begin
      k_busy <= 0;
      k_cnt  <= 0;
    end else if (ap_start && ap_ready) begin
      k_busy <= 1;
      k_cnt  <= 1;
    end else if (k_busy) begin
      if (ap_done) k_busy <= 0;
      else k_cnt <= k_cnt + 1;
    end
  end

  task automatic send(input logic [15:0] c);
    @(negedge clk);
    cmd_valid = 1;
    cmd_count = c;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  // cycles from the first post-handshake cycle until rsp_valid; -1 if it never arrives
  task automatic wait_rsp(output int cnt, output logic [31:0] st);
    cnt = 0;
    st = 0;
    while (!rsp_valid && cnt < 100) begin
      if (ap_start) st[cnt] = 1;
      @(negedge clk);
      cnt++;
    end
    if (!rsp_valid) cnt = -1;
  endtask

  task automatic test_reset;
    checks += 7;
    if (cmd_ready !== 1) begin errors++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
    if (busy !== 0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (ap_start !== 0) begin errors++; $display("FAIL reset_ap_start got %0b want 0", ap_start); end
    if (rsp_valid !== 0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    if (rsp_timeout !== 0) begin errors++; $display("FAIL reset_timeout got %0b want 0", rsp_timeout); end
    if (rsp_runs !== 0) begin errors++; $display("FAIL reset_runs got %0d want 0", rsp_runs); end
    if (rsp_cycles !== 0) begin errors++; $display("FAIL reset_cycles got %0d want 0", rsp_cycles); end
  endtask

  task automatic test_zero;
    send(0);
    wait_rsp(n, starts);
    checks += 6;
    if (n !== 0) begin errors++; $display("FAIL zero_latency got %0d want 0", n); end
    if (starts !== 0) begin errors++; $display("FAIL zero_starts got %h want 0", starts); end
    if (rsp_runs !== 0) begin errors++; $display("FAIL zero_runs got %0d want 0", rsp_runs); end
    if (rsp_cycles !== 0) begin errors++; $display("FAIL zero_cycles got %0d want 0", rsp_cycles); end
    if (rsp_timeout !== 0) begin errors++; $display("FAIL zero_timeout got %0b want 0", rsp_timeout); end
    @(negedge clk);
    if (cmd_ready !== 1) begin errors++; $display("FAIL zero_idle got %0b want 1", cmd_ready); end
  endtask

  task automatic test_single;
    send(1);
    wait_rsp(n, starts);
    checks += 5;
    if (n !== 4) begin errors++; $display("FAIL single_latency got %0d want 4", n); end
    if (starts !== 32'h1) begin errors++; $display("FAIL single_starts got %h want 1", starts); end
    if (rsp_runs !== 1) begin errors++; $display("FAIL single_runs got %0d want 1", rsp_runs); end
    if (rsp_cycles !== 4) begin errors++; $display("FAIL single_cycles got %0d want 4", rsp_cycles); end
    if (rsp_timeout !== 0) begin errors++; $display("FAIL single_timeout got %0b want 0", rsp_timeout); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    send(2);
    wait_rsp(n, starts);
    checks += 4;
    if (n !== 8) begin errors++; $display("FAIL b2b_latency got %0d want 8", n); end
    if (starts !== 32'h11) begin errors++; $display("FAIL b2b_starts got %h want 11", starts); end
    if (rsp_runs !== 2) begin errors++; $display("FAIL b2b_runs got %0d want 2", rsp_runs); end
    if (rsp_cycles !== 8) begin errors++; $display("FAIL b2b_cycles got %0d want 8", rsp_cycles); end
    @(negedge clk);
  endtask

  task automatic test_watchdog;
    hang = 1;
    send(3);
    wait_rsp(n, starts);
    checks += 4;
    if (n !== 4) begin errors++; $display("FAIL wd_latency got %0d want 4", n); end
    if (rsp_runs !== 0) begin errors++; $display("FAIL wd_runs got %0d want 0", rsp_runs); end
    if (rsp_cycles !== 4) begin errors++; $display("FAIL wd_cycles got %0d want 4", rsp_cycles); end
    if (rsp_timeout !== 1) begin errors++; $display("FAIL wd_timeout got %0b want 1", rsp_timeout); end
    @(negedge clk);
    rst = 1;
    hang = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_tie;
    send(3);
    wait_rsp(n, starts);
    checks += 4;
    if (n !== 12) begin errors++; $display("FAIL tie_latency got %0d want 12", n); end
    if (rsp_runs !== 3) begin errors++; $display("FAIL tie_runs got %0d want 3", rsp_runs); end
    if (rsp_cycles !== 12) begin errors++; $display("FAIL tie_cycles got %0d want 12", rsp_cycles); end
    if (rsp_timeout !== 0) begin errors++; $display("FAIL tie_timeout got %0b want 0", rsp_timeout); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    rsp_ready = 0;
    send(1);
    wait_rsp(n, starts);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bp_latency got %0d want 4", n); end
    for (int i = 0; i < 5; i++) begin
      checks += 6;
      if (rsp_valid !== 1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", i, rsp_valid); end
      if (rsp_runs !== 1) begin errors++; $display("FAIL bp_runs[%0d] got %0d want 1", i, rsp_runs); end
      if (rsp_cycles !== 4) begin errors++; $display("FAIL bp_cycles[%0d] got %0d want 4", i, rsp_cycles); end
      if (rsp_timeout !== 0) begin errors++; $display("FAIL bp_timeout[%0d] got %0b want 0", i, rsp_timeout); end
      if (cmd_ready !== 0) begin errors++; $display("FAIL bp_cmd_ready[%0d] got %0b want 0", i, cmd_ready); end
      if (busy !== 1) begin errors++; $display("FAIL bp_busy[%0d] got %0b want 1", i, busy); end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    checks += 3;
    if (cmd_ready !== 1) begin errors++; $display("FAIL bp_idle_ready got %0b want 1", cmd_ready); end
    if (busy !== 0) begin errors++; $display("FAIL bp_idle_busy got %0b want 0", busy); end
    if (rsp_valid !== 0) begin errors++; $display("FAIL bp_idle_valid got %0b want 0", rsp_valid); end
  endtask

  task automatic test_mid_reset;
    send(1);
    @(negedge clk);
    checks++;
    if (ap_start !== 0 || busy !== 1) begin errors++; $display("FAIL mr_in_wait got start=%0b busy=%0b want 0/1", ap_start, busy); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks += 4;
    if (ap_start !== 0) begin errors++; $display("FAIL mr_ap_start got %0b want 0", ap_start); end
    if (rsp_valid !== 0) begin errors++; $display("FAIL mr_rsp_valid got %0b want 0", rsp_valid); end
    if (cmd_ready !== 1) begin errors++; $display("FAIL mr_cmd_ready got %0b want 1", cmd_ready); end
    if (busy !== 0) begin errors++; $display("FAIL mr_busy got %0b want 0", busy); end
    send(1);
    wait_rsp(n, starts);
    checks += 4;
    if (n !== 4) begin errors++; $display("FAIL mr_latency got %0d want 4", n); end
    if (rsp_runs !== 1) begin errors++; $display("FAIL mr_runs got %0d want 1", rsp_runs); end
    if (rsp_cycles !== 4) begin errors++; $display("FAIL mr_cycles got %0d want 4", rsp_cycles); end
    if (rsp_timeout !== 0) begin errors++; $display("FAIL mr_timeout got %0b want 0", rsp_timeout); end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset;
    test_zero;
    test_single;
    test_back_to_back;
    test_watchdog;
    test_tie;
    test_backpressure;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
